// File: rtl/seg_display_mux_if.sv
// Stopwatch digit inputs and multiplexed two-digit 7-segment outputs.
interface seg_display_mux_if;
  logic [3:0] us;
  logic [2:0] zs;
  logic       en;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame;

  modport master (output us, zs, en, input seg, an, frame);
  modport slave  (input us, zs, en, output seg, an, frame);
endinterface

// File: rtl/seg_display_mux.sv
// Two-digit multiplexed 7-segment driver with dark gaps between digits and a
// per-frame snapshot of the stopwatch value so a frame never mixes two readings.
module seg_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYC     = 16,
  parameter int LZ_BLANK    = 1
) (
  input logic              clk,
  input logic              rst,
  seg_display_mux_if.slave bus
);

  // state | meaning
  // DIG0  | units digit lit
  // GAP0  | all dark between units and tens
  // DIG1  | tens digit lit (or dark when blanked)
  // GAP1  | all dark; leaving it loads the snapshot
  typedef enum logic [1:0] {DIG0, GAP0, DIG1, GAP1} state_t;

  localparam logic [20:0] DIG_LAST = 21'(REFRESH_DIV - 1);
  localparam logic [20:0] GAP_LAST = 21'(GAP_CYC - 1);
  localparam logic [6:0]  DARK     = 7'b1111111;
  localparam logic [6:0]  DASH     = 7'b0111111;

  state_t      state, state_nx;
  logic [20:0] cnt, cnt_nx, last;
  logic [3:0]  snap_u, snap_u_nx;
  logic [2:0]  snap_t, snap_t_nx;
  logic        load;
  logic [1:0]  an_nx;
  logic [6:0]  seg_nx;

  function automatic logic [6:0] encode(input logic [3:0] v);
    case (v)
      4'd0:    encode = 7'b1000000;
      4'd1:    encode = 7'b1111001;
      4'd2:    encode = 7'b0100100;
      4'd3:    encode = 7'b0110000;
      4'd4:    encode = 7'b0011001;
      4'd5:    encode = 7'b0010010;
      4'd6:    encode = 7'b0000010;
      4'd7:    encode = 7'b1111000;
      4'd8:    encode = 7'b0000000;
      4'd9:    encode = 7'b0010000;
      default: encode = DASH;
    endcase
  endfunction

  always_comb begin
    last      = (state == DIG0 || state == DIG1) ? DIG_LAST : GAP_LAST;
    state_nx  = state;
    cnt_nx    = cnt + 21'd1;
    load      = 1'b0;
    if (cnt == last) begin
      cnt_nx = '0;
      case (state)
        DIG0: state_nx = GAP0;
        GAP0: state_nx = DIG1;
        DIG1: state_nx = GAP1;
        GAP1: begin
          state_nx = DIG0;
          load     = 1'b1;
        end
        default: state_nx = GAP1;
      endcase
    end
    snap_u_nx = load ? bus.us : snap_u;
    snap_t_nx = load ? bus.zs : snap_t;

    // Outputs are computed for the state being entered so the registered
    // pins line up with the state the FSM is in during the next cycle.
    an_nx  = 2'b11;
    seg_nx = DARK;
    if (bus.en) begin
      if (state_nx == DIG0) begin
        an_nx  = 2'b10;
        seg_nx = encode(snap_u_nx);
      end else if (state_nx == DIG1 && !(LZ_BLANK != 0 && snap_t_nx == 3'd0)) begin
        an_nx  = 2'b01;
        seg_nx = (snap_t_nx > 3'd5) ? DASH : encode({1'b0, snap_t_nx});
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= GAP1;
      cnt       <= '0;
      snap_u    <= '0;
      snap_t    <= '0;
      bus.an    <= 2'b11;
      bus.seg   <= DARK;
      bus.frame <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      snap_u    <= snap_u_nx;
      snap_t    <= snap_t_nx;
      bus.an    <= an_nx;
      bus.seg   <= seg_nx;
      bus.frame <= load;
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux: two instances (leading-zero blanking on and off)
// compared every cycle against a frame-position reference model.
module tb_seg_display_mux;
  localparam int DIV    = 4;
  localparam int GAP    = 2;
  localparam int PERIOD = 2 * (DIV + GAP);
  localparam logic [8:0] DARK = 9'b11_1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  logic       clk;
  logic       rst_n;
  logic [3:0] us_v;
  logic [2:0] zs_v;
  logic       en_v;
  int errors = 0;
  int checks = 0;

  seg_display_mux_if ia ();
  seg_display_mux_if ib ();
  assign ia.us = us_v;
  assign ia.zs = zs_v;
  assign ia.en = en_v;
  assign ib.us = us_v;
  assign ib.zs = zs_v;
  assign ib.en = en_v;

  seg_display_mux #(.REFRESH_DIV(DIV), .GAP_CYC(GAP), .LZ_BLANK(1)) dut_a (.clk(clk), .rst(rst_n), .bus(ia));
  seg_display_mux #(.REFRESH_DIV(DIV), .GAP_CYC(GAP), .LZ_BLANK(0)) dut_b (.clk(clk), .rst(rst_n), .bus(ib));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: position within the frame from the number of edges since reset.
  function automatic int pos(input int n);
    return (n < GAP) ? -1 : (n - GAP) % PERIOD;
  endfunction

  function automatic logic [6:0] ref_seg(input int v);
    logic [6:0] t [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (v >= 0 && v < 10) ? t[v] : DASH;
  endfunction

  function automatic logic [8:0] ref_out(input int n, input int su, input int st, input logic en, input bit lz);
    int p;
    p = pos(n);
    if (!en || p < 0) return DARK;
    if (p < DIV) return {2'b10, ref_seg(su)};
    if (p >= DIV + GAP && p < 2 * DIV + GAP) begin
      if (lz && st == 0) return DARK;
      return {2'b01, (st < 6) ? ref_seg(st) : DASH};
    end
    return DARK;
  endfunction

  int         m_n, m_su, m_st;
  logic [8:0] e_a, e_b;
  logic       e_fr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n  <= 0;
      m_su <= 0;
      m_st <= 0;
      e_a  <= DARK;
      e_b  <= DARK;
      e_fr <= 1'b0;
    end else begin
      m_n  <= m_n + 1;
      if (pos(m_n + 1) == 0) begin
        m_su <= int'(us_v);
        m_st <= int'(zs_v);
      end
      e_fr <= (pos(m_n + 1) == 0);
      e_a  <= ref_out(m_n + 1, pos(m_n + 1) == 0 ? int'(us_v) : m_su,
                      pos(m_n + 1) == 0 ? int'(zs_v) : m_st, en_v, 1'b1);
      e_b  <= ref_out(m_n + 1, pos(m_n + 1) == 0 ? int'(us_v) : m_su,
                      pos(m_n + 1) == 0 ? int'(zs_v) : m_st, en_v, 1'b0);
    end
  end

  task automatic test_reset();
    int p;
    logic [8:0] ex;
    rst_n = 1'b0; us_v = 4'd3; zs_v = 3'd2; en_v = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {DARK, 1'b0, DARK, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got a=%b_%b_%b b=%b_%b_%b want dark, frame 0",
               ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 2 * PERIOD; c++) begin
      @(negedge clk);
      p  = (c < GAP) ? -1 : (c - GAP) % PERIOD;
      ex = (p >= 0 && p < 4) ? {2'b10, 7'b0110000} :
           (p >= 6 && p < 10) ? {2'b01, 7'b0100100} : DARK;
      checks++;
      if ({ia.an, ia.seg, ia.frame} !== {ex, p == 0}) begin
        errors++;
        $display("FAIL reset_latency c=%0d: got %b_%b_%b want %b_%b", c, ia.an, ia.seg, ia.frame, ex, p == 0);
      end
      checks++;
      if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {e_a, e_fr, e_b, e_fr}) begin
        errors++;
        $display("FAIL reset_model c=%0d: got a=%b_%b_%b b=%b_%b_%b want a=%b b=%b fr=%b",
                 c, ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame, e_a, e_b, e_fr);
      end
    end
  endtask

  task automatic test_lz_blank();
    bit a_tens = 0, b_tens_ok = 0, a_units = 0;
    us_v = 4'd7; zs_v = 3'd0;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      @(negedge clk);
      checks++;
      if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {e_a, e_fr, e_b, e_fr}) begin
        errors++;
        $display("FAIL lz_model c=%0d: got a=%b_%b_%b b=%b_%b_%b want a=%b b=%b fr=%b",
                 c, ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame, e_a, e_b, e_fr);
      end
      if (c >= PERIOD) begin
        if (ia.an == 2'b01) a_tens = 1;
        if (ia.an == 2'b10 && ia.seg == 7'b1111000) a_units = 1;
        if (ib.an == 2'b01 && ib.seg == 7'b1000000) b_tens_ok = 1;
      end
    end
    checks++;
    if ({a_tens, a_units, b_tens_ok} !== 3'b011) begin
      errors++;
      $display("FAIL lz_summary: got tens_lit_lz1=%b units7=%b tens0_lz0=%b want 0 1 1", a_tens, a_units, b_tens_ok);
    end
  endtask

  task automatic test_snapshot();
    bit seen = 0, after = 0;
    us_v = 4'd5; zs_v = 3'd1;
    for (int c = 0; c < 2 * PERIOD && !seen; c++) begin
      @(negedge clk);
      if (ia.frame) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL snap_frame_wait: got no frame want frame"); end
    for (int c = 0; c < 7; c++) @(negedge clk);
    us_v = 4'd6;
    for (int c = 0; c < 2 * PERIOD; c++) begin
      @(negedge clk);
      if (ia.frame) after = 1;
      checks++;
      if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {e_a, e_fr, e_b, e_fr}) begin
        errors++;
        $display("FAIL snap_model c=%0d: got a=%b_%b_%b b=%b_%b_%b want a=%b b=%b fr=%b",
                 c, ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame, e_a, e_b, e_fr);
      end
      if (ia.an == 2'b10) begin
        checks++;
        if (ia.seg !== (after ? 7'b0000010 : 7'b0010010)) begin
          errors++;
          $display("FAIL snap_units c=%0d: got %b want %b", c, ia.seg, after ? 7'b0000010 : 7'b0010010);
        end
      end
    end
  endtask

  task automatic test_invalid();
    bit u_seen = 0, t_seen = 0;
    us_v = 4'd12; zs_v = 3'd7;
    for (int c = 0; c < 3 * PERIOD; c++) begin
      @(negedge clk);
      checks++;
      if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {e_a, e_fr, e_b, e_fr}) begin
        errors++;
        $display("FAIL inv_model c=%0d: got a=%b_%b_%b b=%b_%b_%b want a=%b b=%b fr=%b",
                 c, ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame, e_a, e_b, e_fr);
      end
      if (c >= PERIOD && ia.an == 2'b10 && ia.seg === DASH) u_seen = 1;
      if (c >= PERIOD && ia.an == 2'b01 && ia.seg === DASH) t_seen = 1;
    end
    checks++;
    if ({u_seen, t_seen} !== 2'b11) begin
      errors++;
      $display("FAIL inv_dash: got units_dash=%b tens_dash=%b want 1 1", u_seen, t_seen);
    end
  endtask

  task automatic test_enable();
    bit seen = 0;
    int last_fr = -1;
    us_v = 4'd4; zs_v = 3'd3;
    for (int c = 0; c < 2 * PERIOD && !seen; c++) begin
      @(negedge clk);
      if (ia.frame) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL en_frame_wait: got no frame want frame"); end
    @(negedge clk);
    last_fr = -1;
    for (int c = 0; c < 4 * PERIOD; c++) begin
      if (c == 0) en_v = 1'b0;
      if (c == 7) en_v = 1'b1;
      @(negedge clk);
      checks++;
      if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {e_a, e_fr, e_b, e_fr}) begin
        errors++;
        $display("FAIL en_model c=%0d: got a=%b_%b_%b b=%b_%b_%b want a=%b b=%b fr=%b",
                 c, ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame, e_a, e_b, e_fr);
      end
      if (c == 0) begin
        checks++;
        if ({ia.an, ia.seg} !== DARK) begin
          errors++;
          $display("FAIL en_dark: got %b_%b want %b", ia.an, ia.seg, DARK);
        end
      end
      if (ia.frame) begin
        if (last_fr >= 0) begin
          checks++;
          if (c - last_fr != PERIOD) begin
            errors++;
            $display("FAIL en_frame_spacing: got %0d want %0d", c - last_fr, PERIOD);
          end
        end
        last_fr = c;
      end
    end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    us_v = 4'd9; zs_v = 3'd4; en_v = 1'b1;
    for (int c = 0; c < 2 * PERIOD && !seen; c++) begin
      @(negedge clk);
      if (ia.frame) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL arst_frame_wait: got no frame want frame"); end
    repeat (7) @(negedge clk);
    checks++;
    if (ia.an !== 2'b01) begin
      errors++;
      $display("FAIL arst_precond: got an=%b want 01", ia.an);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {DARK, 1'b0, DARK, 1'b0}) begin
      errors++;
      $display("FAIL arst_immediate: got a=%b_%b_%b b=%b_%b_%b want dark",
               ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 2 * PERIOD; c++) begin
      @(negedge clk);
      checks++;
      if ({ia.frame, ia.an} !== {c % PERIOD == GAP, (c >= GAP && (c - GAP) % PERIOD < DIV) ? 2'b10 :
                                 (c >= GAP && (c - GAP) % PERIOD >= DIV + GAP &&
                                  (c - GAP) % PERIOD < 2 * DIV + GAP) ? 2'b01 : 2'b11}) begin
        errors++;
        $display("FAIL arst_timing c=%0d: got frame=%b an=%b", c, ia.frame, ia.an);
      end
      checks++;
      if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {e_a, e_fr, e_b, e_fr}) begin
        errors++;
        $display("FAIL arst_model c=%0d: got a=%b_%b_%b b=%b_%b_%b want a=%b b=%b fr=%b",
                 c, ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame, e_a, e_b, e_fr);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if ({ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame} !== {e_a, e_fr, e_b, e_fr}) begin
        errors++;
        $display("FAIL rand_model c=%0d: got a=%b_%b_%b b=%b_%b_%b want a=%b b=%b fr=%b",
                 c, ia.an, ia.seg, ia.frame, ib.an, ib.seg, ib.frame, e_a, e_b, e_fr);
      end
      if ($urandom_range(4) == 0) begin
        us_v = 4'($urandom_range(15));
        zs_v = 3'($urandom_range(7));
      end
      if ($urandom_range(19) == 0) en_v = ~en_v;
    end
  endtask

  initial begin
    rst_n = 1'b0; us_v = '0; zs_v = '0; en_v = 1'b1;
    test_reset();
    test_lz_blank();
    test_snapshot();
    test_invalid();
    test_enable();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_display_mux.md
SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles each digit is lit; legal range 2..2^20.
REQ-002 Parameter GAP_CYC, default 16: clk cycles all digits are dark between digits (anti-ghosting); legal range 1..2^20.
REQ-003 Parameter LZ_BLANK, default 1: 1 = suppress tens digit when it is 0.
REQ-004 Port clk  input  1  sole clock, rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 Port us  input  4  seconds units from the stopwatch counter, BCD, nominal 0..9.
REQ-007 Port zs  input  3  seconds tens from the stopwatch counter, nominal 0..5.
REQ-008 Port en  input  1  display enable; 0 = all digits dark.
REQ-009 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port an  output  2  digit enables, active-low; an[0] = units, an[1] = tens.
REQ-011 Port frame  output  1  one-cycle pulse marking a snapshot load.

Function
REQ-012 The FSM SHALL have four states, cycled in this order: DIG0 -> GAP0 -> DIG1 -> GAP1 -> DIG0.
REQ-013 A single cycle counter SHALL count 0..N-1 in each state, with N = REFRESH_DIV in DIG states and N = GAP_CYC in GAP states; at N-1 the FSM SHALL advance and the counter SHALL clear to 0.
REQ-014 On the GAP1->DIG0 transition edge, us and zs SHALL be loaded into snapshot registers and frame SHALL be 1 for exactly that following cycle; between loads, display data SHALL come only from the snapshot (no tearing).
REQ-015 an, seg and frame SHALL be driven from registers only, with no combinational path from us, zs or en.
REQ-016 In GAP0/GAP1: an = 2'b11, seg = 7'b1111111.
REQ-017 In DIG0: an = 2'b10, seg = encode(snapshot units).
REQ-018 In DIG1: an = 2'b01, seg = encode(snapshot tens).
REQ-019 When LZ_BLANK = 1 and snapshot tens = 0, DIG1 SHALL instead drive an = 2'b11, seg = 7'b1111111.
REQ-020 Encoding (active-low) SHALL be:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
REQ-021 Out-of-range values SHALL display dash 0111111: units 10..15, and tens 6..7.
REQ-022 While en = 0, outputs SHALL be an = 2'b11 and seg = 7'b1111111, with FSM, counter, snapshot and frame continuing unaffected; en SHALL take effect on outputs one cycle after it is sampled.
REQ-023 Input changes on the cycle of a snapshot load SHALL be captured with their value at that clock edge.

Reset
REQ-024 Asserting rst (0) SHALL asynchronously set: state = GAP1, counter = 0, snapshots = 0, an = 2'b11, seg = 7'b1111111, frame = 0.
REQ-025 After rst release, the first frame pulse and the first DIG0 SHALL occur GAP_CYC cycles later; one full frame lasts 2*(REFRESH_DIV+GAP_CYC) cycles.
REQ-026 Reset asserted mid-frame SHALL take effect immediately, regardless of clk.

Verification (REFRESH_DIV=4, GAP_CYC=2, LZ_BLANK=1 unless stated)
REQ-027 Reset/latency:
  - Stimulus: release rst with us=3, zs=2, en=1.
  - Response: dark for 2 cycles; then frame pulse; then an=10, seg=0110000 for 4 cycles; then dark for 2; then an=01, seg=0100100 for 4; period 12.
REQ-028 Leading-zero blanking:
  - Stimulus: us=7, zs=0.
  - Response: units shows 1111000; DIG1 window shows an=11.
  - Repeat with LZ_BLANK=0: tens shows an=01, seg=1000000.
REQ-029 Snapshot stability:
  - Stimulus: change us 5->6 during DIG1.
  - Response: display still shows 5 until the next frame pulse, then shows 6; no mixed frame.
REQ-030 Invalid codes:
  - Stimulus: us=12, zs=7.
  - Response: both digits show 0111111.
REQ-031 Enable:
  - Stimulus: drop en for 7 cycles mid-DIG0.
  - Response: outputs are dark one cycle later; frame pulses stay at 12-cycle spacing; the display resumes in the phase-correct state.
REQ-032 Async reset:
  - Stimulus: assert rst mid-DIG1, between clock edges.
  - Response: an=11, seg=1111111 immediately.
  - After release, REQ-025 timing repeats exactly.
